// File: rtl/cam_alloc_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : cam_alloc_ctrl
// Description : Request front-end for the 32x8 cam. Accepts LOOKUP/INSERT
//               (and optionally DELETE) requests, searches the cam, allocates
//               the lowest free entry on an INSERT miss, and returns
//               index/hit/err on a valid/ready response channel. A per-entry
//               valid table masks stale cam contents.
//               Optional feature macro: CAM_ALLOC_DEL_EN (DELETE op and the
//               reserved tombstone key DEL_KEY).
// Revision    : 1.0 - initial release
//==============================================================================
module cam_alloc_ctrl #(
   parameter int          DEPTH   = 32,
   parameter int          AW      = 5,
   parameter int          DW      = 8,
   parameter logic [DW-1:0] DEL_KEY = 8'hFF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_op,
   input  logic [DW-1:0] req_key,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [AW-1:0] resp_idx,
   output logic          resp_hit,
   output logic          resp_err,
   output logic          cam_enable,
   output logic          cam_write,
   output logic [AW-1:0] cam_addr,
   output logic [DW-1:0] cam_data,
   input  logic [AW-1:0] cam_out,
   input  logic          cam_found,
   output logic          full
);

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_search = 3'd1;
   localparam logic [2:0] c_st_check  = 3'd2;
   localparam logic [2:0] c_st_write  = 3'd3;
   localparam logic [2:0] c_st_resp   = 3'd4;

   localparam logic [1:0] c_op_lookup = 2'd0;
   localparam logic [1:0] c_op_insert = 2'd1;

   localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

   logic [2:0]       r_state;
   logic [1:0]       r_op;
   logic [DW-1:0]    r_key;
   logic [AW-1:0]    r_idx;
   logic [DEPTH-1:0] r_valid;
   logic [AW:0]      r_count;
   logic             r_resp_valid;
   logic [AW-1:0]    r_resp_idx;
   logic             r_resp_hit;
   logic             r_resp_err;
   logic             r_cam_enable;
   logic             r_cam_write;
   logic [AW-1:0]    r_cam_addr;
   logic [DW-1:0]    r_cam_data;

   logic             w_full;
   logic             w_hit;
   logic             w_op_rsv;
   logic             w_key_rsv;
   logic [AW-1:0]    w_free_idx;

`ifdef CAM_ALLOC_DEL_EN
   localparam logic [1:0] c_op_delete = 2'd2;
   // Only op 3 is reserved; the tombstone key can never be looked up or stored
   assign w_op_rsv  = (req_op == 2'd3);
   assign w_key_rsv = (req_key == DEL_KEY);
`else
   // Ops 2 and 3 are both reserved; the tombstone key is an ordinary key here
   assign w_op_rsv  = req_op[1];
   assign w_key_rsv = 1'b0 & (req_key == DEL_KEY);
`endif

   assign w_full = (r_count == c_depth);
   // A cam match on an entry we never allocated (or freed) is stale
   assign w_hit  = cam_found & r_valid[cam_out];

   // Lowest-index free entry; scanning downward leaves the lowest one last
   always_comb begin
      w_free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_valid[i]) w_free_idx = AW'(i);
      end
   end

   // Request FSM, valid table, occupancy count and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= c_st_idle;
         r_op         <= '0;
         r_key        <= '0;
         r_idx        <= '0;
         r_valid      <= '0;
         r_count      <= '0;
         r_resp_valid <= 1'b0;
         r_resp_idx   <= '0;
         r_resp_hit   <= 1'b0;
         r_resp_err   <= 1'b0;
         r_cam_enable <= 1'b0;
         r_cam_write  <= 1'b0;
         r_cam_addr   <= '0;
         r_cam_data   <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (req_valid) begin
                  r_op  <= req_op;
                  r_key <= req_key;
                  if (w_op_rsv || w_key_rsv) begin
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                     r_resp_hit   <= 1'b0;
                     r_resp_idx   <= '0;
                     r_state      <= c_st_resp;
                  end else begin
                     r_cam_enable <= 1'b1;
                     r_cam_write  <= 1'b0;
                     r_cam_addr   <= '0;
                     r_cam_data   <= req_key;
                     r_state      <= c_st_search;
                  end
               end
            end
            c_st_search: begin
               r_cam_enable <= 1'b0;
               r_cam_data   <= '0;
               r_state      <= c_st_check;
            end
            c_st_check: begin
               if (w_hit) begin
`ifdef CAM_ALLOC_DEL_EN
                  if (r_op == c_op_delete) begin
                     r_idx        <= cam_out;
                     r_cam_enable <= 1'b1;
                     r_cam_write  <= 1'b1;
                     r_cam_addr   <= cam_out;
                     r_cam_data   <= DEL_KEY;
                     r_state      <= c_st_write;
                  end else
`endif
                  begin
                     r_resp_valid <= 1'b1;
                     r_resp_idx   <= cam_out;
                     r_resp_hit   <= 1'b1;
                     r_resp_err   <= 1'b0;
                     r_state      <= c_st_resp;
                  end
               end else if (r_op == c_op_insert && !w_full) begin
                  r_idx        <= w_free_idx;
                  r_cam_enable <= 1'b1;
                  r_cam_write  <= 1'b1;
                  r_cam_addr   <= w_free_idx;
                  r_cam_data   <= r_key;
                  r_state      <= c_st_write;
               end else begin
                  // LOOKUP/DELETE miss, or INSERT miss with no free entry
                  r_resp_valid <= 1'b1;
                  r_resp_idx   <= '0;
                  r_resp_hit   <= 1'b0;
                  r_resp_err   <= (r_op == c_op_insert);
                  r_state      <= c_st_resp;
               end
            end
            c_st_write: begin
               r_cam_enable <= 1'b0;
               r_cam_write  <= 1'b0;
               r_cam_addr   <= '0;
               r_cam_data   <= '0;
               r_resp_valid <= 1'b1;
               r_resp_idx   <= r_idx;
               r_resp_err   <= 1'b0;
               if (r_op == c_op_insert || r_op == c_op_lookup) begin
                  r_valid[r_idx] <= 1'b1;
                  if (r_count != c_depth) r_count <= r_count + 1'b1;
                  r_resp_hit     <= 1'b0;
               end else begin
                  r_valid[r_idx] <= 1'b0;
                  if (r_count != '0) r_count <= r_count - 1'b1;
                  r_resp_hit     <= 1'b1;
               end
               r_state <= c_st_resp;
            end
            c_st_resp: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_resp_idx   <= '0;
                  r_resp_hit   <= 1'b0;
                  r_resp_err   <= 1'b0;
                  r_state      <= c_st_idle;
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign req_ready  = (r_state == c_st_idle);
   assign full       = w_full;
   assign resp_valid = r_resp_valid;
   assign resp_idx   = r_resp_idx;
   assign resp_hit   = r_resp_hit;
   assign resp_err   = r_resp_err;
   assign cam_enable = r_cam_enable;
   assign cam_write  = r_cam_write;
   assign cam_addr   = r_cam_addr;
   assign cam_data   = r_cam_data;

endmodule
`default_nettype wire
